// File: rtl/bpu_if.sv
// bpu_if: fetch/EXE-side bundle into the branch predictor; stats outputs exist only under BPU_STATS_EN.
interface bpu_if;
  logic [31:0] fetch_pc;
  logic        IM_ready;
  logic        stall;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_uncond;
  logic [31:0] next_pc;
  logic        next_jump;
`ifdef BPU_STATS_EN
  logic [31:0] stat_lookup;
  logic [31:0] stat_pred_taken;
  logic [31:0] stat_update_taken;
  modport master (output fetch_pc, IM_ready, stall, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
                  input next_pc, next_jump, stat_lookup, stat_pred_taken, stat_update_taken);
  modport slave (input fetch_pc, IM_ready, stall, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
                 output next_pc, next_jump, stat_lookup, stat_pred_taken, stat_update_taken);
`else
  modport master (output fetch_pc, IM_ready, stall, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
                  input next_pc, next_jump);
  modport slave (input fetch_pc, IM_ready, stall, upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
                 output next_pc, next_jump);
`endif
endinterface

// File: rtl/bpu.sv
// bpu: next-PC generator with direct-mapped BTB and 2-bit counters; BPU_STATS_EN adds lookup/prediction/update counters.
module bpu #(
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W = 26
) (
  input logic clk,
  input logic rst,
  bpu_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TW = (TAG_W > 30 - IDX_W) ? 30 - IDX_W : TAG_W;
  logic          valid_q  [BTB_ENTRIES];
  logic [1:0]    ctr_q    [BTB_ENTRIES];
  logic [TW-1:0] tag_q    [BTB_ENTRIES];
  logic [31:0]   target_q [BTB_ENTRIES];
  logic [IDX_W-1:0] idx, u_idx;
  logic [TW-1:0]    f_tag, u_tag;
  logic hit, u_hit, hold, pred, u_take;
  logic [1:0] u_ctr, ctr_d;
  logic unused;
  assign unused = ^{bus.fetch_pc, bus.upd_pc};
  assign idx    = bus.fetch_pc[2 +: IDX_W];
  assign f_tag  = bus.fetch_pc[2 + IDX_W +: TW];
  assign u_idx  = bus.upd_pc[2 +: IDX_W];
  assign u_tag  = bus.upd_pc[2 + IDX_W +: TW];
  assign hit    = valid_q[idx] && tag_q[idx] == f_tag;
  assign u_hit  = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign hold   = bus.stall || !bus.IM_ready;
  assign pred   = hit && ctr_q[idx][1];
  assign u_take = bus.upd_taken || bus.upd_uncond;
  assign u_ctr  = ctr_q[u_idx];
  always_comb begin
    ctr_d = bus.upd_uncond ? 2'b11 :
            !bus.upd_taken ? (u_ctr == 2'b00 ? 2'b00 : u_ctr - 2'd1) :
            !u_hit         ? 2'b10 :
            (u_ctr == 2'b11 ? 2'b11 : u_ctr + 2'd1);
    bus.next_pc   = rst ? 32'd0 : hold ? bus.fetch_pc : pred ? target_q[idx] : bus.fetch_pc + 32'd4;
    bus.next_jump = !rst && !hold && pred;
  end
  // Lookup above reads pre-update state; writes land at the edge with no bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bus.upd_valid) begin
      if (u_take || u_hit) ctr_q[u_idx] <= ctr_d;
      if (u_take) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bus.upd_target;
      end
    end
  end
`ifdef BPU_STATS_EN
  logic [31:0] lookup_q, pred_taken_q, update_taken_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_q       <= '0;
      pred_taken_q   <= '0;
      update_taken_q <= '0;
    end else begin
      if (!hold) lookup_q <= lookup_q + 32'd1;
      if (bus.next_jump) pred_taken_q <= pred_taken_q + 32'd1;
      if (bus.upd_valid && u_take) update_taken_q <= update_taken_q + 32'd1;
    end
  end
  assign bus.stat_lookup       = lookup_q;
  assign bus.stat_pred_taken   = pred_taken_q;
  assign bus.stat_update_taken = update_taken_q;
`endif
endmodule

// File: tb/tb_bpu.sv
// tb_bpu: directed checks of prediction, training, aliasing, hold and reset behaviour of bpu.
module tb_bpu;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  bpu_if bif ();
  bpu dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] epc, input logic ej);
    bif.fetch_pc = pc;
    #1;
    chk({tag, ".pc"}, bif.next_pc, epc);
    chk({tag, ".j"}, {31'd0, bif.next_jump}, {31'd0, ej});
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic un);
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = pc;
    bif.upd_target = tgt;
    bif.upd_taken  = tk;
    bif.upd_uncond = un;
    @(posedge clk);
    #1;
    bif.upd_valid  = 1'b0;
    bif.upd_uncond = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bif.fetch_pc = 32'h0;
    bif.IM_ready = 1'b1;
    bif.stall = 1'b0;
    bif.upd_valid = 1'b0;
    bif.upd_pc = '0;
    bif.upd_target = '0;
    bif.upd_taken = 1'b0;
    bif.upd_uncond = 1'b0;
    @(posedge clk);
    #1;
    look("rst", 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    look("post_rst", 32'h0, 32'h4, 1'b0);
    look("cold_40", 32'h40, 32'h44, 1'b0);
    upd(32'h40, 32'h100, 1'b1, 1'b0);
    look("alloc", 32'h40, 32'h100, 1'b1);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    look("nt1", 32'h40, 32'h44, 1'b0);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    look("sat00_inc", 32'h40, 32'h44, 1'b0);
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    look("retarget", 32'h40, 32'h180, 1'b1);
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    upd(32'h40, 32'h180, 1'b1, 1'b0);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    look("sat11_dec", 32'h40, 32'h180, 1'b1);
    upd(32'h40, 32'h0, 1'b0, 1'b0);
    look("dec_to01", 32'h40, 32'h44, 1'b0);
    look("alias", 32'h80, 32'h84, 1'b0);
    upd(32'h60, 32'h600, 1'b0, 1'b0);
    look("miss_nt", 32'h60, 32'h64, 1'b0);
    bif.fetch_pc = 32'h20;
    bif.upd_valid = 1'b1;
    bif.upd_pc = 32'h20;
    bif.upd_target = 32'h200;
    bif.upd_taken = 1'b0;
    bif.upd_uncond = 1'b1;
    #1;
    chk("nobypass.pc", bif.next_pc, 32'h24);
    @(posedge clk);
    #1;
    bif.upd_valid = 1'b0;
    bif.upd_uncond = 1'b0;
    look("uncond", 32'h20, 32'h200, 1'b1);
    upd(32'h20, 32'h0, 1'b0, 1'b0);
    look("uncond_ctr11", 32'h20, 32'h200, 1'b1);
    bif.stall = 1'b1;
    look("stall", 32'h20, 32'h20, 1'b0);
    bif.stall = 1'b0;
    bif.IM_ready = 1'b0;
    look("im_busy", 32'h20, 32'h20, 1'b0);
    bif.IM_ready = 1'b1;
    look("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);
    upd(32'h80, 32'h500, 1'b1, 1'b0);
    look("overwrite", 32'h80, 32'h500, 1'b1);
    look("evicted", 32'h40, 32'h44, 1'b0);
    rst = 1'b1;
    upd(32'h8, 32'h300, 1'b1, 1'b0);
    rst = 1'b0;
    look("rst_wins", 32'h8, 32'hC, 1'b0);
    look("rst_clr", 32'h20, 32'h24, 1'b0);
`ifdef BPU_STATS_EN
    rst = 1'b1;
    bif.fetch_pc = 32'h1000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stat_lookup", bif.stat_lookup, 32'd10);
    chk("stat_pred", bif.stat_pred_taken, 32'd0);
    upd(32'h1000, 32'h2000, 1'b1, 1'b0);
    chk("stat_upd", bif.stat_update_taken, 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
